// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared widths and helpers for the IKA2151 timer slice.
//   TMRA_W      : Timer A counter / reload width
//   TMRB_W      : Timer B counter / reload width
//   PRESCALE_W  : Timer B frame-tick prescaler width
package ika2151_pkg;

    localparam int TMRA_W     = 10;
    localparam int TMRB_W     = 8;
    localparam int PRESCALE_W = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = 4'd15;

    // True on the last prescaler state, where Timer B is allowed to advance.
    function automatic logic prescale_wrap(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_LAST);
    endfunction

endpackage

// File: rtl/ika2151_timer_cntr.sv
// ika2151_timer_cntr: reloadable up-counter shared by Timer A and Timer B.
//   i_EMUCLK  : master clock
//   i_MRST_n  : asynchronous active-low reset
//   tick      : frame tick (already qualified by the phi1 enable)
//   step      : counting permitted on this tick (subset of tick)
//   load      : run level; its rising edge (sampled on ticks) reloads
//   value     : reload value
//   count     : current count (registered)
//   overflow  : combinational, high on the tick the counter wraps past max
module ika2151_timer_cntr #(
    parameter int W = 8
) (
    input  logic         i_EMUCLK,
    input  logic         i_MRST_n,
    input  logic         tick,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         overflow
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         load_prev_r;
    logic         ovfl_s;

    // Next count: a load edge beats everything and never overflows; the
    // edge is seen on any tick, while counting waits for a step.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovfl_s    = 1'b0;
        if (tick) begin
            if (load && !load_prev_r) begin
                cnt_nxt_s = value;
            end else if (step && load && (cnt_r == CNT_MAX)) begin
                cnt_nxt_s = value;
                ovfl_s    = 1'b1;
            end else if (step && load) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and load-edge history advance on frame ticks only.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            cnt_r       <= {W{1'b0}};
            load_prev_r <= 1'b0;
        end else if (tick) begin
            cnt_r       <= cnt_nxt_s;
            load_prev_r <= load;
        end else begin
            cnt_r       <= cnt_r;
            load_prev_r <= load_prev_r;
        end
    end

    assign count    = cnt_r;
    assign overflow = ovfl_s;

endmodule

// File: rtl/ika2151_timer.sv
// ika2151_timer: YM2151 Timer A / Timer B with flags and IRQ.
//   i_EMUCLK, i_MRST_n       : clock, asynchronous active-low reset
//   i_phi1_NCEN_n            : active-low edge enable gating all state
//   i_CYCLE_31               : frame tick strobe from the timing generator
//   i_TMRA_VALUE/i_TMRB_VALUE: reload values
//   i_LOAD_A/i_LOAD_B        : run levels
//   i_IRQEN_A/i_IRQEN_B      : flag-set enables
//   i_FRST_A/i_FRST_B        : flag-clear requests
//   o_TMRA_FLAG/o_TMRB_FLAG  : overflow flags
//   o_IRQ_n                  : active-low interrupt, NOR of the flags
//   o_TMRA_OVFL              : one-interval Timer A overflow pulse
module ika2151_timer
    import ika2151_pkg::*;
(
    input  logic              i_EMUCLK,
    input  logic              i_MRST_n,
    input  logic              i_phi1_NCEN_n,
    input  logic              i_CYCLE_31,
    input  logic [TMRA_W-1:0] i_TMRA_VALUE,
    input  logic [TMRB_W-1:0] i_TMRB_VALUE,
    input  logic              i_LOAD_A,
    input  logic              i_LOAD_B,
    input  logic              i_IRQEN_A,
    input  logic              i_IRQEN_B,
    input  logic              i_FRST_A,
    input  logic              i_FRST_B,
    output logic              o_TMRA_FLAG,
    output logic              o_TMRB_FLAG,
    output logic              o_IRQ_n,
    output logic              o_TMRA_OVFL
);

    logic                  cen_s;
    logic                  tick_s;
    logic                  bstep_s;
    logic [PRESCALE_W-1:0] presc_r;
    logic [TMRA_W-1:0]     cnt_a_s;
    logic [TMRB_W-1:0]     cnt_b_s;
    logic                  ovfl_a_s;
    logic                  ovfl_b_s;
    logic                  flag_a_r;
    logic                  flag_b_r;
    logic                  flag_a_nxt_s;
    logic                  flag_b_nxt_s;
    logic                  ovfl_out_r;
    logic                  unused_cnt_s;

    assign cen_s   = ~i_phi1_NCEN_n;
    assign tick_s  = cen_s & i_CYCLE_31;
    assign bstep_s = tick_s & prescale_wrap(presc_r);

    // Free-running frame prescaler that paces Timer B.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            presc_r <= {PRESCALE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= presc_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            presc_r <= presc_r;
        end
    end

    ika2151_timer_cntr #(.W(TMRA_W)) u_cntr_a (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST_n (i_MRST_n),
        .tick     (tick_s),
        .step     (tick_s),
        .load     (i_LOAD_A),
        .value    (i_TMRA_VALUE),
        .count    (cnt_a_s),
        .overflow (ovfl_a_s)
    );

    ika2151_timer_cntr #(.W(TMRB_W)) u_cntr_b (
        .i_EMUCLK (i_EMUCLK),
        .i_MRST_n (i_MRST_n),
        .tick     (tick_s),
        .step     (bstep_s),
        .load     (i_LOAD_B),
        .value    (i_TMRB_VALUE),
        .count    (cnt_b_s),
        .overflow (ovfl_b_s)
    );

    // Counts are only observation points here; fold them so nothing dangles.
    assign unused_cnt_s = ^{cnt_a_s, cnt_b_s};

    // Flag next state: a set on the same edge as a clear wins.
    always_comb begin
        flag_a_nxt_s = flag_a_r;
        flag_b_nxt_s = flag_b_r;
        if (ovfl_a_s && i_IRQEN_A) begin
            flag_a_nxt_s = 1'b1;
        end else if (i_FRST_A) begin
            flag_a_nxt_s = 1'b0;
        end else begin
            flag_a_nxt_s = flag_a_r;
        end
        if (ovfl_b_s && i_IRQEN_B) begin
            flag_b_nxt_s = 1'b1;
        end else if (i_FRST_B) begin
            flag_b_nxt_s = 1'b0;
        end else begin
            flag_b_nxt_s = flag_b_r;
        end
    end

    // Flags and the overflow pulse update on every enabled edge, so the
    // pulse drops at the first enabled edge after the overflow.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            flag_a_r   <= 1'b0;
            flag_b_r   <= 1'b0;
            ovfl_out_r <= 1'b0;
        end else if (cen_s) begin
            flag_a_r   <= flag_a_nxt_s;
            flag_b_r   <= flag_b_nxt_s;
            ovfl_out_r <= ovfl_a_s;
        end else begin
            flag_a_r   <= flag_a_r;
            flag_b_r   <= flag_b_r;
            ovfl_out_r <= ovfl_out_r;
        end
    end

    assign o_TMRA_FLAG = flag_a_r;
    assign o_TMRB_FLAG = flag_b_r;
    assign o_TMRA_OVFL = ovfl_out_r;
    assign o_IRQ_n     = ~(flag_a_r | flag_b_r);

endmodule

// File: tb/tb_ika2151_timer.sv
// tb_ika2151_timer: directed self-checking bench for ika2151_timer.
module tb_ika2151_timer;

    logic       clk;
    logic       rst_n;
    logic       ncen_n;
    logic       cycle31;
    logic [9:0] tmra;
    logic [7:0] tmrb;
    logic       load_a, load_b, irqen_a, irqen_b, frst_a, frst_b;
    logic       flag_a, flag_b, irq_n, ovfl_a;

    int errors = 0;
    int checks = 0;

    ika2151_timer u_dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (rst_n),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (cycle31),
        .i_TMRA_VALUE  (tmra),
        .i_TMRB_VALUE  (tmrb),
        .i_LOAD_A      (load_a),
        .i_LOAD_B      (load_b),
        .i_IRQEN_A     (irqen_a),
        .i_IRQEN_B     (irqen_b),
        .i_FRST_A      (frst_a),
        .i_FRST_B      (frst_b),
        .o_TMRA_FLAG   (flag_a),
        .o_TMRB_FLAG   (flag_b),
        .o_IRQ_n       (irq_n),
        .o_TMRA_OVFL   (ovfl_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given frame strobe; outputs sampled 1 time unit later.
    task automatic clk_edge(input logic c31);
        cycle31 = c31;
        @(posedge clk);
        #1;
        cycle31 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ncen_n  = 1'b0;
        cycle31 = 1'b0;
        tmra    = 10'd0;
        tmrb    = 8'd0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        irqen_a = 1'b0;
        irqen_b = 1'b0;
        frst_a  = 1'b0;
        frst_b  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        ncen_n  = 1'b1;
        cycle31 = 1'b1;
        tmra    = 10'd1023;
        tmrb    = 8'd255;
        load_a  = 1'b1;
        load_b  = 1'b1;
        irqen_a = 1'b1;
        irqen_b = 1'b1;
        frst_a  = 1'b0;
        frst_b  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flag_a, flag_b, irq_n, ovfl_a} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_disabled flags/irq_n/ovfl got %b want 0010", {flag_a, flag_b, irq_n, ovfl_a});
        end
        ncen_n = 1'b0;
        repeat (3) clk_edge(1'b1);
        checks++;
        if ({flag_a, flag_b, irq_n, ovfl_a, u_dut.cnt_a_s} !== {4'b0010, 10'd0}) begin
            errors++;
            $display("FAIL reset_held flags/irq_n/ovfl/cnt_a got %b/%0d want 0010/0", {flag_a, flag_b, irq_n, ovfl_a}, u_dut.cnt_a_s);
        end
    endtask

    task automatic test_timer_a_period();
        logic exp;
        do_reset();
        tmra    = 10'd1020;
        irqen_a = 1'b1;
        clk_edge(1'b1);
        load_a = 1'b1;
        // tick 1 loads 1020; overflows on ticks 5 and 9
        for (int k = 1; k <= 9; k++) begin
            clk_edge(1'b1);
            exp = (k == 5) || (k == 9);
            checks++;
            if (ovfl_a !== exp) begin
                errors++;
                $display("FAIL a_period tick %0d ovfl got %b want %b", k, ovfl_a, exp);
            end
            if (k == 4 || k == 5) begin
                checks++;
                if ({flag_a, irq_n} !== ((k == 5) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL a_flag tick %0d flag/irq_n got %b want %b", k, {flag_a, irq_n}, (k == 5) ? 2'b10 : 2'b01);
                end
            end
        end
        clk_edge(1'b0);
        checks++;
        if (ovfl_a !== 1'b0) begin
            errors++;
            $display("FAIL a_ovfl_width got %b want 0", ovfl_a);
        end
        irqen_a = 1'b0;
        clk_edge(1'b0);
        checks++;
        if (flag_a !== 1'b1) begin
            errors++;
            $display("FAIL a_irqen_drop flag got %b want 1", flag_a);
        end
        frst_a = 1'b1;
        clk_edge(1'b0);
        frst_a = 1'b0;
        checks++;
        if ({flag_a, irq_n} !== 2'b01) begin
            errors++;
            $display("FAIL a_frst flag/irq_n got %b want 01", {flag_a, irq_n});
        end
    endtask

    task automatic test_timer_b();
        do_reset();
        tmrb   = 8'd254;
        load_b = 1'b1;
        // load at tick 1, B-steps at 16,32,...; overflows at 32, 64, 96
        for (int t = 1; t <= 96; t++) begin
            clk_edge(1'b1);
            if (t == 32) begin
                checks++;
                if ({flag_b, irq_n} !== 2'b01) begin
                    errors++;
                    $display("FAIL b_irqen_off t=%0d flag/irq_n got %b want 01", t, {flag_b, irq_n});
                end
                irqen_b = 1'b1;
            end
            if (t == 63 || t == 64 || t == 95 || t == 96) begin
                checks++;
                if (flag_b !== ((t == 64) || (t == 96))) begin
                    errors++;
                    $display("FAIL b_period t=%0d flag got %b want %b", t, flag_b, (t == 64) || (t == 96));
                end
            end
            if (t == 64) begin
                checks++;
                if (irq_n !== 1'b0) begin
                    errors++;
                    $display("FAIL b_irq t=%0d irq_n got %b want 0", t, irq_n);
                end
                frst_b = 1'b1;
                clk_edge(1'b0);
                frst_b = 1'b0;
                checks++;
                if ({flag_b, irq_n} !== 2'b01) begin
                    errors++;
                    $display("FAIL b_frst flag/irq_n got %b want 01", {flag_b, irq_n});
                end
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        tmra    = 10'd1020;
        irqen_a = 1'b1;
        load_a  = 1'b1;
        clk_edge(1'b1);
        frst_a = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            clk_edge(1'b1);
            if (k >= 4) begin
                checks++;
                if (flag_a !== (k == 5)) begin
                    errors++;
                    $display("FAIL collision tick %0d flag got %b want %b", k, flag_a, k == 5);
                end
            end
        end
        frst_a = 1'b0;
    endtask

    task automatic test_stop_restart();
        do_reset();
        tmra   = 10'd500;
        load_a = 1'b1;
        clk_edge(1'b1);
        load_a = 1'b0;
        repeat (10) clk_edge(1'b1);
        checks++;
        if ({u_dut.cnt_a_s, ovfl_a} !== {10'd500, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold cnt/ovfl got %0d/%b want 500/0", u_dut.cnt_a_s, ovfl_a);
        end
        tmra   = 10'd1020;
        load_a = 1'b1;
        clk_edge(1'b1);
        checks++;
        if ({u_dut.cnt_a_s, ovfl_a} !== {10'd1020, 1'b0}) begin
            errors++;
            $display("FAIL restart_load cnt/ovfl got %0d/%b want 1020/0", u_dut.cnt_a_s, ovfl_a);
        end
        tmra = 10'd1022;
        clk_edge(1'b1);
        ncen_n = 1'b1;
        repeat (3) clk_edge(1'b1);
        ncen_n = 1'b0;
        checks++;
        if (u_dut.cnt_a_s !== 10'd1021) begin
            errors++;
            $display("FAIL enable_gate cnt got %0d want 1021", u_dut.cnt_a_s);
        end
        // 1022, 1023, then overflow reloading the new value 1022
        for (int k = 2; k <= 6; k++) begin
            clk_edge(1'b1);
            checks++;
            if (ovfl_a !== ((k == 4) || (k == 6))) begin
                errors++;
                $display("FAIL restart_ovfl tick %0d got %b want %b", k, ovfl_a, (k == 4) || (k == 6));
            end
        end
    endtask

    task automatic test_irqen_off_async_reset();
        do_reset();
        tmra   = 10'd1023;
        load_a = 1'b1;
        clk_edge(1'b1);
        checks++;
        if (ovfl_a !== 1'b0) begin
            errors++;
            $display("FAIL v1023_load ovfl got %b want 0", ovfl_a);
        end
        for (int k = 2; k <= 6; k++) begin
            clk_edge(1'b1);
            checks++;
            if ({ovfl_a, flag_a, irq_n} !== 3'b101) begin
                errors++;
                $display("FAIL v1023 tick %0d ovfl/flag/irq_n got %b want 101", k, {ovfl_a, flag_a, irq_n});
            end
        end
        irqen_a = 1'b1;
        clk_edge(1'b1);
        checks++;
        if ({ovfl_a, flag_a, irq_n} !== 3'b110) begin
            errors++;
            $display("FAIL pre_async ovfl/flag/irq_n got %b want 110", {ovfl_a, flag_a, irq_n});
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ovfl_a, flag_a, flag_b, irq_n, u_dut.cnt_a_s} !== {4'b0001, 10'd0}) begin
            errors++;
            $display("FAIL async_reset ovfl/flags/irq_n/cnt got %b/%0d want 0001/0", {ovfl_a, flag_a, flag_b, irq_n}, u_dut.cnt_a_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clk_edge(1'b1);
        checks++;
        if (ovfl_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_load ovfl got %b want 0", ovfl_a);
        end
        clk_edge(1'b1);
        checks++;
        if (ovfl_a !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ovfl got %b want 1", ovfl_a);
        end
    endtask

    initial begin
        test_reset();
        test_timer_a_period();
        test_timer_b();
        test_collision();
        test_stop_restart();
        test_irqen_off_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
